wormhole_output_allocator: RTL and testbench



---
 rtl/wormhole_output_allocator.sv | 139 +++++++++++++
 tb/tb_wormhole_output_allocator.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wormhole_output_allocator.sv
// Wormhole output-port allocator: each free output grants one heading input by
// round-robin and stays locked to it until that packet's tail is accepted.
module wormhole_output_allocator #(
    parameter int PORTS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PORTS-1:0]         req_valid,
    input  logic [PORTS-1:0]         req_head,
    input  logic [PORTS-1:0]         req_tail,
    input  logic [PORTS*$clog2(PORTS)-1:0] req_dest,
    input  logic [PORTS-1:0]         out_ack,
    output logic [PORTS-1:0]         in_grant,
    output logic [PORTS*$clog2(PORTS)-1:0] in_route,
    output logic [PORTS-1:0]         out_busy,
    output logic [PORTS*$clog2(PORTS)-1:0] out_sel
);
    localparam int SEL_W = $clog2(PORTS);

    typedef enum logic {
        FREE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e           state_q [PORTS];
    state_e           state_d [PORTS];
    logic [SEL_W-1:0] sel_q   [PORTS];
    logic [SEL_W-1:0] sel_d   [PORTS];
    logic [SEL_W-1:0] ptr_q   [PORTS];
    logic [SEL_W-1:0] ptr_d   [PORTS];
    logic [SEL_W-1:0] route_q [PORTS];
    logic [SEL_W-1:0] route_d [PORTS];
    logic [PORTS-1:0] grant_q;
    logic [PORTS-1:0] grant_d;
    logic [PORTS-1:0] req_mat [PORTS];

    function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base,
                                                  input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        return SEL_W'(s % PORTS);
    endfunction

    // req_mat[o][i]: input i is an ungranted header asking for output o
    always_comb begin
        for (int unsigned o = 0; o < PORTS; o++) begin
            req_mat[o] = '0;
            for (int unsigned i = 0; i < PORTS; i++) begin
                req_mat[o][i] = req_valid[i] && req_head[i] && !grant_q[i] &&
                                (req_dest[i*SEL_W +: SEL_W] == SEL_W'(o));
            end
        end
    end

    always_comb begin
        logic [SEL_W-1:0] owner;
        logic [SEL_W-1:0] winner;
        logic [SEL_W-1:0] cand;
        logic             found;
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        route_d = route_q;
        grant_d = grant_q;
        owner   = '0;
        winner  = '0;
        cand    = '0;
        found   = 1'b0;
        // Release only touches granted inputs and allocation only ungranted
        // ones, so the per-output updates never collide on an input.
        for (int unsigned o = 0; o < PORTS; o++) begin
            if (state_q[o] == LOCKED) begin
                owner = sel_q[o];
                if (req_valid[owner] && req_tail[owner] && out_ack[o]) begin
                    state_d[o]     = FREE;
                    sel_d[o]       = '0;
                    ptr_d[o]       = wrap_add(owner, 1);
                    grant_d[owner] = 1'b0;
                    route_d[owner] = '0;
                end
            end else begin
                found  = 1'b0;
                winner = '0;
                for (int unsigned k = 0; k < PORTS; k++) begin
                    cand = wrap_add(ptr_q[o], k);
                    if (!found && req_mat[o][cand]) begin
                        found  = 1'b1;
                        winner = cand;
                    end
                end
                if (found) begin
                    state_d[o]      = LOCKED;
                    sel_d[o]        = winner;
                    grant_d[winner] = 1'b1;
                    route_d[winner] = SEL_W'(o);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned o = 0; o < PORTS; o++) begin
                state_q[o] <= FREE;
                sel_q[o]   <= '0;
                ptr_q[o]   <= '0;
                route_q[o] <= '0;
            end
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            route_q <= route_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        in_grant = grant_q;
        in_route = '0;
        out_busy = '0;
        out_sel  = '0;
        for (int unsigned p = 0; p < PORTS; p++) begin
            in_route[p*SEL_W +: SEL_W] = route_q[p];
            out_busy[p]                = (state_q[p] == LOCKED);
            out_sel[p*SEL_W +: SEL_W]  = sel_q[p];
        end
    end

    // Ownership must agree in both directions between outputs and inputs.
    for (genvar g = 0; g < PORTS; g++) begin : g_own_chk
        assert property (@(posedge clk) disable iff (rst)
            (state_q[g] == LOCKED) |-> (grant_q[sel_q[g]] && route_q[sel_q[g]] == SEL_W'(g)));
        assert property (@(posedge clk) disable iff (rst)
            grant_q[g] |-> (state_q[route_q[g]] == LOCKED && sel_q[route_q[g]] == SEL_W'(g)));
    end

endmodule

// File: tb/tb_wormhole_output_allocator.sv
// Directed bench for wormhole_output_allocator: an ownership-table model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_wormhole_output_allocator;
    localparam int P = 4;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [P-1:0]    req_valid, req_head, req_tail, out_ack;
    logic [P*SW-1:0] req_dest;
    logic [P-1:0]    in_grant, out_busy;
    logic [P*SW-1:0] in_route, out_sel;

    int total = 0;
    int bad   = 0;

    // model: owner of each output (-1 = free) and round-robin start per output
    int m_owner [P];
    int m_ptr   [P];
    bit started = 1'b0;

    wormhole_output_allocator #(.PORTS(P)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_head(req_head), .req_tail(req_tail),
        .req_dest(req_dest), .out_ack(out_ack),
        .in_grant(in_grant), .in_route(in_route),
        .out_busy(out_busy), .out_sel(out_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic int holder_of(input int i, input int owners [P]);
        for (int o = 0; o < P; o++) if (owners[o] == i) return o;
        return -1;
    endfunction

    always @(posedge clk) begin
        int prev [P];
        int d;
        started = 1'b1;
        if (rst) begin
            for (int o = 0; o < P; o++) begin
                m_owner[o] = -1;
                m_ptr[o]   = 0;
            end
        end else begin
            prev = m_owner;
            for (int o = 0; o < P; o++) begin
                if (prev[o] >= 0) begin
                    if (req_valid[prev[o]] && req_tail[prev[o]] && out_ack[o]) begin
                        m_owner[o] = -1;
                        m_ptr[o]   = (prev[o] + 1) % P;
                    end
                end else begin
                    for (int k = 0; k < P; k++) begin
                        int i;
                        i = (m_ptr[o] + k) % P;
                        d = int'(req_dest[i*SW +: SW]);
                        if (m_owner[o] < 0 && req_valid[i] && req_head[i] &&
                            holder_of(i, prev) < 0 && d == o)
                            m_owner[o] = i;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [P-1:0]    eg, eb;
        logic [P*SW-1:0] er, es;
        if (started) begin
            eg = '0; eb = '0; er = '0; es = '0;
            for (int o = 0; o < P; o++) begin
                if (m_owner[o] >= 0) begin
                    eb[o] = 1'b1;
                    es[o*SW +: SW] = SW'(m_owner[o]);
                    eg[m_owner[o]] = 1'b1;
                    er[m_owner[o]*SW +: SW] = SW'(o);
                end
            end
            chk("model_in_grant", 32'(in_grant), 32'(eg));
            chk("model_in_route", 32'(in_route), 32'(er));
            chk("model_out_busy", 32'(out_busy), 32'(eb));
            chk("model_out_sel",  32'(out_sel),  32'(es));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = '0; req_head = '0; req_tail = '0; out_ack = '0; req_dest = '0;
    endtask

    task automatic head(input int i, input int d);
        req_valid[i] = 1'b1; req_head[i] = 1'b1; req_tail[i] = 1'b0;
        req_dest[i*SW +: SW] = SW'(d);
    endtask

    task automatic tail(input int i, input int o);
        req_valid[i] = 1'b1; req_head[i] = 1'b0; req_tail[i] = 1'b1;
        out_ack[o] = 1'b1;
    endtask

    task automatic drop(input int i);
        req_valid[i] = 1'b0; req_head[i] = 1'b0; req_tail[i] = 1'b0;
    endtask

    function automatic int fld(input logic [P*SW-1:0] v, input int i);
        return int'(v[i*SW +: SW]);
    endfunction

    task automatic chk_idle(input string name);
        chk({name, "_grant"}, 32'(in_grant), 0);
        chk({name, "_route"}, 32'(in_route), 0);
        chk({name, "_busy"},  32'(out_busy), 0);
        chk({name, "_sel"},   32'(out_sel),  0);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk_idle("reset_idle");
            tick();
        end

        // single packet: input 2 -> output 1, tail at cycle 5
        head(2, 1);
        tick();
        chk("t2_grant", 32'(in_grant), 32'h4);
        chk("t2_route2", fld(in_route, 2), 1);
        chk("t2_sel1", fld(out_sel, 1), 2);
        chk("t2_busy", 32'(out_busy), 32'h2);
        req_head[2] = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        chk("t2_hold_sel1", fld(out_sel, 1), 2);
        tail(2, 1);
        tick();
        chk_idle("t2_release");
        clear_inputs();
        // ptr[1] is now 3, so input 3 beats input 0
        head(0, 1); head(3, 1);
        tick();
        chk("t2_ptr_grant", 32'(in_grant), 32'h8);
        chk("t2_ptr_sel1", fld(out_sel, 1), 3);
        tail(3, 1);
        tick();
        chk("t2_rel3_busy", 32'(out_busy), 0);
        chk("t2_rel3_grant", 32'(in_grant), 0);
        drop(3); out_ack = '0;
        tick();
        chk("t2_wait0_grant", 32'(in_grant), 32'h1);
        chk("t2_wait0_busy", 32'(out_busy), 32'h2);
        req_head[0] = 1'b0;
        rst = 1'b1;
        tick();
        chk_idle("mid_lock_reset");
        rst = 1'b0;
        clear_inputs();
        tick();

        // three-way contention on output 2
        head(0, 2); head(1, 2); head(3, 2);
        tick();
        chk("t3_first", 32'(in_grant), 32'h1);
        chk("t3_first_busy", 32'(out_busy), 32'h4);
        tail(0, 2);
        tick();
        chk("t3_rel0_busy", 32'(out_busy), 0);
        drop(0); out_ack = '0;
        tick();
        chk("t3_second", 32'(in_grant), 32'h2);
        chk("t3_second_sel", fld(out_sel, 2), 1);
        tail(1, 2);
        tick();
        chk("t3_rel1_busy", 32'(out_busy), 0);
        drop(1); out_ack = '0;
        tick();
        chk("t3_third", 32'(in_grant), 32'h8);
        chk("t3_third_sel", fld(out_sel, 2), 3);
        tail(3, 2);
        tick();
        chk_idle("t3_done");
        clear_inputs();
        tick();

        // priority carry-over on output 0
        head(3, 0);
        tick();
        chk("t4_own3", 32'(in_grant), 32'h8);
        tail(3, 0);
        tick();
        clear_inputs();
        head(0, 0); head(3, 0);
        tick();
        chk("t4_own0", 32'(in_grant), 32'h1);
        chk("t4_busy", 32'(out_busy), 32'h1);
        drop(3);
        tail(0, 0);
        tick();
        clear_inputs();
        tick();

        // parallel allocation
        head(0, 3); head(1, 2);
        tick();
        chk("t5_busy", 32'(out_busy), 32'hC);
        chk("t5_grant", 32'(in_grant), 32'h3);
        chk("t5_route0", fld(in_route, 0), 3);
        chk("t5_route1", fld(in_route, 1), 2);
        tail(0, 3); tail(1, 2);
        tick();
        chk_idle("t5_done");
        clear_inputs();
        tick();

        // single-flit packet, ack delayed; non-owner header while locked
        head(1, 0); req_tail[1] = 1'b1;
        tick();
        chk("t6_grant", 32'(in_grant), 32'h2);
        chk("t6_sel0", fld(out_sel, 0), 1);
        head(2, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t6_locked_sel0", fld(out_sel, 0), 1);
            chk("t6_locked_busy", 32'(out_busy), 32'h1);
        end
        out_ack[0] = 1'b1;
        tick();
        chk("t6_rel_busy", 32'(out_busy), 0);
        chk("t6_rel_grant", 32'(in_grant), 0);
        drop(1); out_ack = '0;
        tick();
        chk("t6_next_sel0", fld(out_sel, 0), 2);
        chk("t6_next_grant", 32'(in_grant), 32'h4);
        tail(2, 0);
        tick();
        chk_idle("t6_done");
        clear_inputs();
        for (int c = 0; c < 3; c++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
